seq_stage_ctrl: RTL and testbench

Multi-cycle sequencer for the Y86-64 SEQ core. It steps each instruction through fetch, decode, execute, memory, writeback and PC update, and issues one-cycle enables to each stage. The execute stage gets a dedicated condition-code update enable. The block also handshakes with instruction and data memory, skips the memory stage for non-memory instructions, and tracks processor status (AOK/HLT/ADR/INS) plus cycle and retired-instruction counters.

---
 rtl/seq_stage_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_seq_stage_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/seq_stage_ctrl.sv
// Multi-cycle stage sequencer for the Y86-64 SEQ core: walks each instruction
// through F/D/E/M/W/PC, handshakes with imem/dmem and tracks status and counters.
module seq_stage_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             start_i,
   input  logic [3:0]       icode_i,
   input  logic             imem_ack_i,
   input  logic             imem_error_i,
   input  logic             dmem_ack_i,
   input  logic             dmem_error_i,
   output logic             imem_req_o,
   output logic             dmem_req_o,
   output logic             dmem_we_o,
   output logic             d_en_o,
   output logic             e_en_o,
   output logic             cc_en_o,
   output logic             w_en_o,
   output logic             pc_en_o,
   output logic [2:0]       stat_o,
   output logic             running_o,
   output logic [CNT_W-1:0] cycle_cnt_o,
   output logic [CNT_W-1:0] instret_o
);

   localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [2:0] STAT_HLT = 3'd2;
   localparam logic [2:0] STAT_ADR = 3'd3;
   localparam logic [2:0] STAT_INS = 3'd4;

   localparam logic [3:0] IC_HALT   = 4'h0;
   localparam logic [3:0] IC_RMMOVQ = 4'h4;
   localparam logic [3:0] IC_MRMOVQ = 4'h5;
   localparam logic [3:0] IC_OPQ    = 4'h6;
   localparam logic [3:0] IC_CALL   = 4'h8;
   localparam logic [3:0] IC_RET    = 4'h9;
   localparam logic [3:0] IC_PUSHQ  = 4'hA;
   localparam logic [3:0] IC_POPQ   = 4'hB;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WBACK, S_PCUPD, S_HALT
   } state_t;

   state_t            r_state, w_state_nxt;
   logic [2:0]        r_stat, w_stat_nxt;
   logic [3:0]        r_icode, w_icode_nxt;
   logic [WAIT_W-1:0] r_wait, w_wait_nxt;
   logic [CNT_W-1:0]  r_cycle, r_instret;
   logic              w_is_mem, w_is_wr, w_timeout;

   // icode classes are taken from the latched icode so outputs stay Moore
   always_comb begin
      w_is_mem = 1'b0;
      w_is_wr  = 1'b0;
      case (r_icode)
         IC_RMMOVQ, IC_CALL, IC_PUSHQ: begin w_is_mem = 1'b1; w_is_wr = 1'b1; end
         IC_MRMOVQ, IC_RET,  IC_POPQ:  w_is_mem = 1'b1;
         default: ;
      endcase
   end

   assign w_timeout = (r_wait == WAIT_LAST);

   always_comb begin
      w_state_nxt = r_state;
      w_stat_nxt  = r_stat;
      w_icode_nxt = r_icode;
      w_wait_nxt  = r_wait;
      case (r_state)
         S_IDLE: begin
            if (start_i) begin
               w_state_nxt = S_FETCH;
               w_wait_nxt  = '0;
            end
         end
         S_FETCH: begin
            if (imem_ack_i) begin
               if (imem_error_i) begin
                  w_stat_nxt  = STAT_ADR;
                  w_state_nxt = S_HALT;
               end else if (icode_i > IC_POPQ) begin
                  w_stat_nxt  = STAT_INS;
                  w_state_nxt = S_HALT;
               end else begin
                  w_icode_nxt = icode_i;
                  w_state_nxt = S_DECODE;
               end
            end else if (w_timeout) begin
               w_stat_nxt  = STAT_ADR;
               w_state_nxt = S_HALT;
            end else begin
               w_wait_nxt = r_wait + 1'b1;
            end
         end
         S_DECODE: begin
            if (r_icode == IC_HALT) begin
               w_stat_nxt  = STAT_HLT;
               w_state_nxt = S_HALT;
            end else begin
               w_state_nxt = S_EXEC;
            end
         end
         S_EXEC: begin
            if (w_is_mem) begin
               w_state_nxt = S_MEM;
               w_wait_nxt  = '0;
            end else begin
               w_state_nxt = S_WBACK;
            end
         end
         S_MEM: begin
            // an ack in the same cycle as the timeout still completes the access
            if (dmem_ack_i) begin
               if (dmem_error_i) begin
                  w_stat_nxt  = STAT_ADR;
                  w_state_nxt = S_HALT;
               end else begin
                  w_state_nxt = S_WBACK;
               end
            end else if (w_timeout) begin
               w_stat_nxt  = STAT_ADR;
               w_state_nxt = S_HALT;
            end else begin
               w_wait_nxt = r_wait + 1'b1;
            end
         end
         S_WBACK: w_state_nxt = S_PCUPD;
         S_PCUPD: begin
            w_state_nxt = S_FETCH;
            w_wait_nxt  = '0;
         end
         S_HALT:  w_state_nxt = S_HALT;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state <= S_IDLE;
         r_stat  <= STAT_AOK;
         r_icode <= '0;
         r_wait  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_stat  <= w_stat_nxt;
         r_icode <= w_icode_nxt;
         r_wait  <= w_wait_nxt;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_cycle   <= '0;
         r_instret <= '0;
      end else begin
         if (running_o)          r_cycle   <= r_cycle + 1'b1;
         if (r_state == S_PCUPD) r_instret <= r_instret + 1'b1;
      end
   end

   always_comb begin
      imem_req_o = 1'b0;
      dmem_req_o = 1'b0;
      dmem_we_o  = 1'b0;
      d_en_o     = 1'b0;
      e_en_o     = 1'b0;
      cc_en_o    = 1'b0;
      w_en_o     = 1'b0;
      pc_en_o    = 1'b0;
      case (r_state)
         S_FETCH:  imem_req_o = 1'b1;
         S_DECODE: d_en_o     = 1'b1;
         S_EXEC: begin
            e_en_o  = 1'b1;
            cc_en_o = (r_icode == IC_OPQ);
         end
         S_MEM: begin
            dmem_req_o = 1'b1;
            dmem_we_o  = w_is_wr;
         end
         S_WBACK:  w_en_o     = 1'b1;
         S_PCUPD:  pc_en_o    = 1'b1;
         default: ;
      endcase
   end

   assign running_o   = (r_state != S_IDLE) && (r_state != S_HALT);
   assign stat_o      = r_stat;
   assign cycle_cnt_o = r_cycle;
   assign instret_o   = r_instret;

endmodule

// File: tb/tb_seq_stage_ctrl.sv
// Directed bench for seq_stage_ctrl: per-cycle enable vectors, status codes,
// counters and async reset, with MEM_TIMEOUT shortened to 4.
module tb_seq_stage_ctrl;
   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
   logic [3:0] icode = 4'h0;
   logic imem_ack = 1'b0, imem_err = 1'b0, dmem_ack = 1'b0, dmem_err = 1'b0;
   logic imem_req, dmem_req, dmem_we, d_en, e_en, cc_en, w_en, pc_en, running;
   logic [2:0] stat;
   logic [31:0] cycle_cnt, instret;
   int errors = 0, checks = 0;

   seq_stage_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .icode_i(icode),
      .imem_ack_i(imem_ack), .imem_error_i(imem_err),
      .dmem_ack_i(dmem_ack), .dmem_error_i(dmem_err),
      .imem_req_o(imem_req), .dmem_req_o(dmem_req), .dmem_we_o(dmem_we),
      .d_en_o(d_en), .e_en_o(e_en), .cc_en_o(cc_en), .w_en_o(w_en), .pc_en_o(pc_en),
      .stat_o(stat), .running_o(running), .cycle_cnt_o(cycle_cnt), .instret_o(instret)
   );

   always #5 clk = ~clk;

   // {imem_req, dmem_req, dmem_we, d_en, e_en, cc_en, w_en, pc_en}
   function automatic logic [7:0] outv();
      return {imem_req, dmem_req, dmem_we, d_en, e_en, cc_en, w_en, pc_en};
   endfunction

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      start = 0; imem_ack = 0; imem_err = 0; dmem_ack = 0; dmem_err = 0; icode = 0;
      rst_n = 0; tick(); tick(); rst_n = 1; tick();
   endtask

   task automatic do_start();
      start = 1; tick(); start = 0;
   endtask

   task automatic test_reset();
      do_reset();
      for (int i = 0; i < 2; i++) begin
         checks++; if (outv() !== 8'h00) begin errors++; $display("FAIL reset_vec got %h want 00", outv()); end
         checks++; if (stat !== 3'd1 || running !== 1'b0) begin errors++; $display("FAIL reset_stat got stat=%0d run=%b want 1/0", stat, running); end
         checks++; if (cycle_cnt !== 0 || instret !== 0) begin errors++; $display("FAIL reset_cnt got %0d/%0d want 0/0", cycle_cnt, instret); end
         tick();
      end
   endtask

   task automatic test_nop_x3();
      logic [0:4][7:0] exp = {8'h80, 8'h10, 8'h08, 8'h02, 8'h01};
      do_reset(); do_start();
      for (int k = 0; k < 3; k++)
         for (int c = 0; c < 5; c++) begin
            checks++; if (outv() !== exp[c]) begin errors++; $display("FAIL nop i%0d c%0d got %h want %h", k, c, outv(), exp[c]); end
            imem_ack = (c == 0); icode = 4'h1;
            tick();
         end
      checks++; if (instret !== 3) begin errors++; $display("FAIL nop_instret got %0d want 3", instret); end
      checks++; if (cycle_cnt !== 15) begin errors++; $display("FAIL nop_cycles got %0d want 15", cycle_cnt); end
      checks++; if (stat !== 3'd1 || running !== 1'b1) begin errors++; $display("FAIL nop_stat got %0d/%b want 1/1", stat, running); end
   endtask

   task automatic test_opq();
      logic [0:4][7:0] exp = {8'h80, 8'h10, 8'h0C, 8'h02, 8'h01};
      do_reset(); do_start();
      for (int c = 0; c < 5; c++) begin
         checks++; if (outv() !== exp[c]) begin errors++; $display("FAIL opq c%0d got %h want %h", c, outv(), exp[c]); end
         imem_ack = (c == 0); icode = 4'h6;
         tick();
      end
      checks++; if (instret !== 1 || cycle_cnt !== 5) begin errors++; $display("FAIL opq_cnt got %0d/%0d want 1/5", instret, cycle_cnt); end
   endtask

   // ack arrives on the 4th MEM cycle, which is also the timeout boundary
   task automatic test_mem_wait(input logic [3:0] ic, input logic [7:0] mv);
      logic [0:8][7:0] exp;
      exp = {8'h80, 8'h10, 8'h08, mv, mv, mv, mv, 8'h02, 8'h01};
      do_reset(); do_start();
      for (int c = 0; c < 9; c++) begin
         checks++; if (outv() !== exp[c]) begin errors++; $display("FAIL mem_ic%h c%0d got %h want %h", ic, c, outv(), exp[c]); end
         imem_ack = (c == 0); icode = ic; dmem_ack = (c == 6);
         tick();
      end
      checks++; if (instret !== 1 || cycle_cnt !== 9) begin errors++; $display("FAIL mem_ic%h_cnt got %0d/%0d want 1/9", ic, instret, cycle_cnt); end
      checks++; if (stat !== 3'd1) begin errors++; $display("FAIL mem_ic%h_stat got %0d want 1", ic, stat); end
   endtask

   task automatic test_fetch_faults();
      logic [3:0] ic [3] = '{4'h1, 4'hC, 4'h0};
      logic       er [3] = '{1'b1, 1'b0, 1'b0};
      logic [2:0] st [3] = '{3'd3, 3'd4, 3'd2};
      for (int t = 0; t < 3; t++) begin
         do_reset(); do_start();
         imem_ack = 1; imem_err = er[t]; icode = ic[t];
         tick();
         imem_ack = 0; imem_err = 0;
         if (t == 2) begin
            checks++; if (outv() !== 8'h10) begin errors++; $display("FAIL halt_decode got %h want 10", outv()); end
            tick();
         end
         start = 1;
         for (int c = 0; c < 3; c++) begin
            checks++; if (outv() !== 8'h00) begin errors++; $display("FAIL fault%0d c%0d vec got %h want 00", t, c, outv()); end
            checks++; if (stat !== st[t] || running !== 1'b0) begin errors++; $display("FAIL fault%0d c%0d stat got %0d/%b want %0d/0", t, c, stat, running, st[t]); end
            tick();
         end
         start = 0;
         checks++; if (instret !== 0) begin errors++; $display("FAIL fault%0d instret got %0d want 0", t, instret); end
      end
   endtask

   task automatic test_mem_timeout();
      do_reset(); do_start();
      imem_ack = 1; icode = 4'h5; tick(); imem_ack = 0;
      tick(); tick();
      for (int c = 0; c < 4; c++) begin
         checks++; if (outv() !== 8'h40 || stat !== 3'd1) begin errors++; $display("FAIL tmo m%0d got %h/%0d want 40/1", c, outv(), stat); end
         tick();
      end
      checks++; if (stat !== 3'd3 || running !== 1'b0 || outv() !== 8'h00) begin errors++; $display("FAIL tmo_halt got %0d/%b/%h want 3/0/00", stat, running, outv()); end
      checks++; if (instret !== 0) begin errors++; $display("FAIL tmo_instret got %0d want 0", instret); end
   endtask

   task automatic test_async_reset();
      do_reset(); do_start();
      imem_ack = 1; icode = 4'h4; tick(); imem_ack = 0;
      tick(); tick();
      checks++; if (outv() !== 8'h60) begin errors++; $display("FAIL ar_mem got %h want 60", outv()); end
      #2 rst_n = 0; #1;
      checks++; if (outv() !== 8'h00 || running !== 1'b0 || stat !== 3'd1) begin errors++; $display("FAIL ar_out got %h/%b/%0d want 00/0/1", outv(), running, stat); end
      checks++; if (cycle_cnt !== 0 || instret !== 0) begin errors++; $display("FAIL ar_cnt got %0d/%0d want 0/0", cycle_cnt, instret); end
      #1 rst_n = 1;
      tick(); do_start();
      for (int c = 0; c < 5; c++) begin
         imem_ack = (c == 0); icode = 4'h1; tick();
      end
      imem_ack = 0;
      checks++; if (cycle_cnt !== 5 || instret !== 1) begin errors++; $display("FAIL ar_restart got %0d/%0d want 5/1", cycle_cnt, instret); end
   endtask

   initial begin
      test_reset();
      test_nop_x3();
      test_opq();
      test_mem_wait(4'h5, 8'h40);
      test_mem_wait(4'hA, 8'h60);
      test_fetch_faults();
      test_mem_timeout();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
